mem_arbiter: RTL

//  Shares the single unified memory port of the multicycle CPU between two requesters:
//  the CPU datapath (instruction fetch and data access) and a DMA/boot-loader port.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter that shares the single memory port of a
//                multicycle CPU between the CPU datapath and a DMA/boot-loader
//                port. Each grant runs one non-overlapped memory transaction
//                (IDLE -> ISSUE -> WAIT x MEM_LAT -> DONE) and ends with a
//                one-cycle ack plus registered read data for the owner.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                i_cpu_* / o_cpu_*      - CPU request / ack / read data
//                i_dma_* / o_dma_*      - DMA request / ack / read data
//                o_mem_*, i_mem_rdata   - shared memory port
//                o_busy, o_owner        - activity flag, current owner (1=DMA)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  // CPU requester
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  // DMA requester
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  // Memory port
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  // Status
  output logic              o_busy,
  output logic              o_owner
);

  // Counter holds MEM_LAT-1 down to 0; keep at least one bit for MEM_LAT == 1.
  localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_we;          // latched direction, held for the whole transaction
  logic               r_last_owner;  // 0 = CPU, 1 = DMA
  logic               r_owner;
  logic               r_busy;
  logic               r_cpu_ack;
  logic               r_dma_ack;
  logic [DATA_W-1:0]  r_cpu_rdata;
  logic [DATA_W-1:0]  r_dma_rdata;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;

  logic w_any_req;
  logic w_grant_dma;

  assign w_any_req = i_cpu_req | i_dma_req;
  // DMA wins when it is alone, or on a tie when the CPU was served last.
  assign w_grant_dma = i_dma_req & (~i_cpu_req | ~r_last_owner);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant_dma;
            r_last_owner <= w_grant_dma;
            r_we         <= w_grant_dma ? i_dma_we    : i_cpu_we;
            r_mem_we     <= w_grant_dma ? i_dma_we    : i_cpu_we;
            r_mem_addr   <= w_grant_dma ? i_dma_addr  : i_cpu_addr;
            r_mem_wdata  <= w_grant_dma ? i_dma_wdata : i_cpu_wdata;
            r_mem_en     <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Strobe and write enable are one-cycle; address/data stay latched.
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= c_CNT_LOAD;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            // This is the cycle MEM_LAT after the strobe: read data is valid now.
            if (!r_we) begin
              if (r_owner) r_dma_rdata <= i_mem_rdata;
              else         r_cpu_rdata <= i_mem_rdata;
            end
            r_cpu_ack <= ~r_owner;
            r_dma_ack <= r_owner;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_cpu_ack <= 1'b0;
          r_dma_ack <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dma_ack   = r_dma_ack;
  assign o_dma_rdata = r_dma_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_owner     = r_owner;

endmodule
`default_nettype wire
